conv1_pool: RTL

CONV1_POOL -- requirements
Module: conv1_pool

---
 rtl/cnn_pkg.sv | 16 +
 rtl/relu_max.sv | 40 ++++
 rtl/conv1_pool.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/cnn_pkg.sv
// Shared constants and FSM encoding for the layer-1 conv / pool datapath.
package cnn_pkg;

  localparam int CNN_CHAN      = 4;     // parallel conv channels
  localparam int DATA_W        = 8;     // lane width of every conv sample
  localparam int CNN_OUTLENPER = 61;    // conv outputs per segment
  localparam int CNN_OUTLENALL = 2562;  // conv outputs per layer run (42 segments)

  // IDLE: no partial window, ACC: window partially filled, DONE: run finished
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DONE = 2'd2
  } pool_state_t;

endpackage

// File: rtl/relu_max.sv
// One 8-bit pooling lane: ReLU on the incoming sample plus a running-max
// register that is loaded at window start, updated mid-window and cleared
// when the window closes or is discarded.
module relu_max
  import cnn_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [DATA_W-1:0] din_i,
  input  logic                     en_i,      // sample belongs to a window
  input  logic                     first_i,   // sample opens a new window
  input  logic                     clr_i,     // window closed or discarded
  output logic        [DATA_W-1:0] win_max_o  // window max including din_i
);

  logic [DATA_W-1:0] max_q;
  logic [DATA_W-1:0] max_d;
  logic [DATA_W-1:0] relu_v;

  // Negative samples floor to zero; positives keep their 7-bit magnitude.
  function automatic logic [DATA_W-1:0] relu(input logic signed [DATA_W-1:0] x);
    return x[DATA_W-1] ? '0 : $unsigned(x);
  endfunction

  // Combinational window max so the completing sample is visible to the write.
  always_comb begin
    relu_v    = relu(din_i);
    win_max_o = (first_i || (relu_v > max_q)) ? relu_v : max_q;
    max_d     = max_q;
    if (clr_i)     max_d = '0;
    else if (en_i) max_d = win_max_o;
  end

  // Running-max register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) max_q <= '0;
    else     max_q <= max_d;
  end

endmodule

// File: rtl/conv1_pool.sv
// Layer-1 ReLU + max-pool: consumes CHAN conv output streams, pools POOL
// consecutive valid samples per channel without crossing segment boundaries,
// and writes each pooled vector into the layer-2 input buffer.
module conv1_pool
  import cnn_pkg::*;
#(
  parameter int CHAN      = CNN_CHAN,
  parameter int POOL      = 2,
  parameter int OUTLENPER = CNN_OUTLENPER,
  parameter int OUTLENALL = CNN_OUTLENALL,
  parameter int AW        = 11
) (
  input  logic                     clk,
  input  logic                     global_rst,
  input  logic                     valid_in,
  input  logic                     end_in,
  input  logic signed [DATA_W-1:0] data_in1,
  input  logic signed [DATA_W-1:0] data_in2,
  input  logic signed [DATA_W-1:0] data_in3,
  input  logic signed [DATA_W-1:0] data_in4,
  output logic                     wr_en,
  output logic        [AW-1:0]     wr_addr,
  output logic [DATA_W*CHAN-1:0]   wr_data,
  output logic                     pool_done,
  output logic                     err_extra
);

  localparam int SEG_W = $clog2(OUTLENPER + 1);
  localparam int TOT_W = $clog2(OUTLENALL + 1);
  localparam int WIN_W = $clog2(POOL + 1);

  localparam logic [SEG_W-1:0] SEG_LAST = SEG_W'(OUTLENPER - 1);
  // First segment index that cannot fill a whole window (the dropped tail).
  localparam logic [SEG_W-1:0] SEG_FULL = SEG_W'((OUTLENPER / POOL) * POOL);
  localparam logic [TOT_W-1:0] TOT_LAST = TOT_W'(OUTLENALL - 1);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(POOL - 1);

  pool_state_t               state_q, state_d;
  logic [SEG_W-1:0]          seg_cnt_q, seg_cnt_d;
  logic [TOT_W-1:0]          tot_cnt_q, tot_cnt_d;
  logic [WIN_W-1:0]          win_cnt_q, win_cnt_d;
  logic [AW-1:0]             wr_cnt_q, wr_cnt_d;
  logic [AW-1:0]             wr_addr_q, wr_addr_d;
  logic [DATA_W*CHAN-1:0]    wr_data_q, wr_data_d;
  logic                      wr_en_q, wr_en_d;
  logic                      done_q, done_d;
  logic                      err_q, err_d;

  logic                      acc, tail, take, first, complete, go_done;
  logic signed [DATA_W-1:0]  lane_in [4];
  logic [DATA_W*CHAN-1:0]    win_pack;

  assign lane_in[0] = data_in1;
  assign lane_in[1] = data_in2;
  assign lane_in[2] = data_in3;
  assign lane_in[3] = data_in4;

  // Sample qualification shared by the lanes and the counters.
  always_comb begin
    acc      = valid_in && (state_q != ST_DONE);
    tail     = (seg_cnt_q >= SEG_FULL);
    take     = acc && !tail;
    first    = (win_cnt_q == '0);
    complete = take && (win_cnt_q == WIN_LAST);
    go_done  = (state_q != ST_DONE) && (end_in || (acc && (tot_cnt_q == TOT_LAST)));
  end

  for (genvar g = 0; g < CHAN; g++) begin : g_lane
    relu_max u_lane (
      .clk       (clk),
      .rst       (global_rst),
      .din_i     (lane_in[g]),
      .en_i      (take),
      .first_i   (first),
      .clr_i     (complete || go_done),
      .win_max_o (win_pack[g*DATA_W +: DATA_W])
    );
  end

  // Next-state: counters, FSM, write strobe and sticky flags.
  always_comb begin
    state_d   = state_q;
    seg_cnt_d = seg_cnt_q;
    tot_cnt_d = tot_cnt_q;
    win_cnt_d = win_cnt_q;
    wr_cnt_d  = wr_cnt_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    wr_en_d   = complete;
    done_d    = done_q || go_done;
    err_d     = err_q || (valid_in && (state_q == ST_DONE));

    if (acc) begin
      seg_cnt_d = (seg_cnt_q == SEG_LAST) ? '0 : seg_cnt_q + 1'b1;
      tot_cnt_d = tot_cnt_q + 1'b1;
      state_d   = ST_IDLE;
    end
    if (take) begin
      win_cnt_d = complete ? '0 : win_cnt_q + 1'b1;
      state_d   = complete ? ST_IDLE : ST_ACC;
    end
    if (complete) begin
      wr_data_d = win_pack;
      wr_addr_d = wr_cnt_q;
      wr_cnt_d  = wr_cnt_q + 1'b1;
    end
    // The same-cycle sample is processed above; any partial window is dropped.
    if (go_done) begin
      state_d   = ST_DONE;
      win_cnt_d = '0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge global_rst) begin
    if (global_rst) begin
      state_q   <= ST_IDLE;
      seg_cnt_q <= '0;
      tot_cnt_q <= '0;
      win_cnt_q <= '0;
      wr_cnt_q  <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_en_q   <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      seg_cnt_q <= seg_cnt_d;
      tot_cnt_q <= tot_cnt_d;
      win_cnt_q <= win_cnt_d;
      wr_cnt_q  <= wr_cnt_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      wr_en_q   <= wr_en_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign pool_done = done_q;
  assign err_extra = err_q;

endmodule
